// File: rtl/reg_file_2r1w.sv
// ---------------------------------------------------------------------------
// reg_file_2r1w
// Architectural general-purpose register file for the single-cycle CPU.
// Two combinational read ports feed the ALU operands, a third combinational
// port serves debug, and one synchronous port takes the writeback result.
// Register 0 is hardwired to zero and has no storage behind it.
//
// Ports:
//   clk       in   system clock, state updates on the rising edge
//   rst_n     in   asynchronous active-low reset, clears every register
//   RegWrite  in   write enable from the control unit
//   RW        in   write address (from the rt/rd write-address mux)
//   W         in   write data (ALU result or memory data)
//   RA, RB    in   read addresses for ports A (rs) and B (rt)
//   A, B      out  read data for ports A and B
//   DbgAddr   in   debug read address
//   DbgData   out  debug read data, same read rules as A and B
//
// Parameters:
//   DATA_W  register / data-port width
//   ADDR_W  address width, depth is 2**ADDR_W
//   BYPASS  1: a read of the address being written shows W this cycle
// ---------------------------------------------------------------------------
module reg_file_2r1w #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter bit BYPASS = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              RegWrite,
   input  logic [ADDR_W-1:0] RW,
   input  logic [DATA_W-1:0] W,
   input  logic [ADDR_W-1:0] RA,
   input  logic [ADDR_W-1:0] RB,
   output logic [DATA_W-1:0] A,
   output logic [DATA_W-1:0] B,
   input  logic [ADDR_W-1:0] DbgAddr,
   output logic [DATA_W-1:0] DbgData
);

   localparam int DEPTH = 2 ** ADDR_W;

   // Entry 0 is never stored; the arrays start at index 1.
   logic [DATA_W-1:0] mem_q [1:DEPTH-1];
   logic [DATA_W-1:0] mem_d [1:DEPTH-1];

   // A write is only effective for a non-zero address. RegWrite=0 forces
   // this low even when RW carries unknowns, so state cannot be disturbed.
   logic wr_en;
   assign wr_en = RegWrite && (RW != '0);

   // Next-state for every stored register: hold, unless it is the target
   // of an effective write this cycle.
   always_comb begin
      for (int i = 1; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
         if (wr_en && (RW == ADDR_W'(i))) begin
            mem_d[i] = W;
         end
      end
   end

   // Register array. Reset has priority, so a write coinciding with reset
   // (or pending when reset arrives) is lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 1; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         for (int i = 1; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   // Read ports. Address 0 falls through to the zero default. The optional
   // bypass substitutes W for the stored value of the address being written,
   // and reset forces every port to zero so the bypass cannot leak W then.
   always_comb begin
      A       = '0;
      B       = '0;
      DbgData = '0;
      for (int i = 1; i < DEPTH; i++) begin
         if (RA == ADDR_W'(i)) begin
            A = mem_q[i];
         end
         if (RB == ADDR_W'(i)) begin
            B = mem_q[i];
         end
         if (DbgAddr == ADDR_W'(i)) begin
            DbgData = mem_q[i];
         end
      end
      if (BYPASS && wr_en) begin
         if (RA == RW) begin
            A = W;
         end
         if (RB == RW) begin
            B = W;
         end
         if (DbgAddr == RW) begin
            DbgData = W;
         end
      end
      if (!rst_n) begin
         A       = '0;
         B       = '0;
         DbgData = '0;
      end
   end

endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- Architectural general-purpose register file of the single-cycle CPU.
- Sits directly downstream of the 5-bit 2:1 write-register-address mux (rt/rd select). The mux output drives the write-address port RW.
- Provides two combinational read ports that feed the ALU operand path and one synchronous write port that takes the writeback result.
- Register 0 is hardwired to zero, per the MIPS convention.

Parameters:
- DATA_W, 32, width of each register and of the data ports.
- ADDR_W, 5, address width; depth = 2**ADDR_W = 32 entries.
- BYPASS, 0, when 1, a read of the address being written this cycle returns the write data (W) instead of the stored value.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- RegWrite  input  1  write enable from the control unit.
- RW  input  ADDR_W  write address; driven by the write-address mux output O.
- W  input  DATA_W  write data (ALU result or memory data).
- RA  input  ADDR_W  read address, port A (rs).
- RB  input  ADDR_W  read address, port B (rt).
- A  output  DATA_W  read data, port A.
- B  output  DATA_W  read data, port B.
- DbgAddr  input  ADDR_W  debug read address.
- DbgData  output  DATA_W  debug read data (combinational, same rules as ports A and B).

Behaviour:
- Reset:
  - rst_n low clears all 32 registers to 0 immediately, without waiting for clk.
  - While rst_n is low, A, B and DbgData read 0 for every address.
  - Writes are ignored while rst_n is low.
  - Deassertion is sampled by clk. The first write can occur on the first rising edge where rst_n is high.
- Write:
  - On the rising edge of clk, if rst_n=1, RegWrite=1 and RW!=0, then mem[RW] <= W.
  - Latency: the new value is visible on the read ports immediately after that edge, with 0 extra cycles.
- Register 0:
  - Writes with RW=0 are dropped.
  - Reads of address 0 always return 0 on A, B and DbgData.
  - No storage element is required for entry 0.
- Read:
  - A = mem[RA], B = mem[RB], DbgData = mem[DbgAddr].
  - Reads are purely combinational, with no clock dependence.
  - All three ports are independent; RA = RB = DbgAddr is legal.
- Same-cycle read/write of the same address (RegWrite=1, RW==RA or RW==RB, RW!=0):
  - BYPASS=0: the read port shows the old value until the edge, then the new value.
  - BYPASS=1: the read port shows W combinationally during that cycle.
  - BYPASS has no effect when RW=0.
- Simultaneous write and reset: reset wins, and the register ends at 0.
- Reset mid-operation: an asynchronous assertion between edges clears all contents. A write pending for the next edge is lost.
- Unknown inputs: RegWrite=0 means no state change, regardless of X on RW or W.
- No overflow or wrap concerns: addresses are exactly ADDR_W bits, and all 32 addresses are valid.

Test Plan:
1. Reset clear:
   - Write 0xDEADBEEF to R5, then pulse rst_n low for 3 ns mid-cycle with no clk edge.
   - Required: A with RA=5 reads 0x00000000 immediately.
2. Basic write/read:
   - Drive RegWrite=1, RW=8, W=0x12345678 for one edge, then RegWrite=0.
   - Required: RA=8 gives A=0x12345678; RB=8 gives B=0x12345678.
   - Required: a later edge with RegWrite=0 and W=0xFFFFFFFF leaves R8 unchanged.
3. R0 hardwire:
   - Drive RegWrite=1, RW=0, W=0xFFFFFFFF for one edge.
   - Required: RA=0 gives A=0, and DbgAddr=0 gives DbgData=0.
4. Write-address mux path:
   - Stage A: mux A=3, B=17, Sel=1 drives RW=17; W=0x000000AA, RegWrite=1.
   - Required: R17=0xAA and R3 unchanged (0).
   - Stage B: Sel=0 drives RW=3; W=0x55.
   - Required: R3=0x55 and R17 still 0xAA.
5. Same-cycle hazard:
   - R9 holds 0x1111. Drive RegWrite=1, RW=9, RA=9, W=0x2222.
   - Required with BYPASS=0: A=0x1111 before the edge and 0x2222 after.
   - Required with BYPASS=1: A=0x2222 before the edge.
6. Full sweep:
   - Write i*0x01010101 to R1..R31 on consecutive edges.
   - Required: read back all 31 entries on A and B, with RA=i and RB=31-i, and every value matches; R0 reads 0.
